vc_drain_arbiter: RTL and testbench

Read side of the per-VC FIFOs: pulls words from two upstream threshold FIFOs (VC0 high priority, VC1 low priority) and forwards them as one registered stream toward the egress stage. Uses the FIFOs' empty and almost_full flags to decide which FIFO to pop. Honours a downstream almost_full pause. Pop strobes match the FIFO read port, which presents read data combinationally in the same cycle that rd is high and the FIFO is not empty.

---
 rtl/vc_drain_arbiter.sv | 138 +++++++++++++
 tb/tb_vc_drain_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_drain_arbiter.sv
// vc_drain_arbiter: drains two per-VC threshold FIFOs into one registered stream.
// VC0 has priority over VC1. A VC1 FIFO that is almost full and not empty overrides that priority.
// A downstream almost_full parks the arbiter in PAUSE.
// Pop strobes are combinational and match the FIFO read port. Read data is valid in the cycle rd is high.
// Optional macro VC_DRAIN_WEIGHTED_RR_EN adds a VC0 burst counter.
// With it, VC1 gets a slot after WEIGHT consecutive VC0 pops while VC1 is waiting.
//
// state  | meaning
// IDLE   | both FIFOs empty, nothing to pop
// SERVE0 | VC0 owns this cycle, pop if non-empty and not backpressured
// SERVE1 | VC1 owns this cycle, pop if non-empty and not backpressured
// PAUSE  | downstream almost full, no pops
module vc_drain_arbiter #(
    parameter int BW     = 6,
    parameter int WEIGHT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [BW-1:0] vc0_data,
    input  logic          vc0_empty,
    input  logic          vc0_almost_full,
    output logic          vc0_rd,
    input  logic [BW-1:0] vc1_data,
    input  logic          vc1_empty,
    input  logic          vc1_almost_full,
    output logic          vc1_rd,
    input  logic          down_almost_full,
    output logic [BW-1:0] data_out,
    output logic          valid_out,
    output logic          vc_id,
    output logic          idle
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        SERVE1 = 2'd2,
        PAUSE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;
    state_t sel_state;
    logic   burst_limit;

    if (WEIGHT < 1 || WEIGHT > 15) begin : g_bad_weight
        $error("vc_drain_arbiter: WEIGHT must be in 1..15");
    end

    // VC0 is already the preferred source, so its high-threshold flag changes nothing.
    logic unused_vc0_af;
    assign unused_vc0_af = vc0_almost_full;

    assign vc0_rd = !reset && (state == SERVE0) && !vc0_empty && !down_almost_full;
    assign vc1_rd = !reset && (state == SERVE1) && !vc1_empty && !down_almost_full;
    assign idle   = (state == IDLE);

`ifdef VC_DRAIN_WEIGHTED_RR_EN
    localparam logic [3:0] WEIGHT_CNT = 4'(WEIGHT);

    logic [3:0] burst_cnt;
    logic [3:0] burst_cnt_next;

    // Burst count after this cycle's pop, so the limit bounds the run at WEIGHT pops.
    always_comb begin
        burst_cnt_next = burst_cnt;
        if (vc1_rd || vc1_empty) begin
            burst_cnt_next = 4'd0;
        end else if (vc0_rd && (burst_cnt != WEIGHT_CNT)) begin
            burst_cnt_next = burst_cnt + 4'd1;
        end
    end

    assign burst_limit = (burst_cnt_next == WEIGHT_CNT) && !vc1_empty;

    // Burst counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            burst_cnt <= 4'd0;
        end else begin
            burst_cnt <= burst_cnt_next;
        end
    end
`else
    assign burst_limit = 1'b0;
`endif

    // Owner selection from the current cycle's flags.
    always_comb begin
        sel_state = IDLE;
        if (vc1_almost_full && !vc1_empty) begin
            sel_state = SERVE1;
        end else if (burst_limit) begin
            sel_state = SERVE1;
        end else if (!vc0_empty) begin
            sel_state = SERVE0;
        end else if (!vc1_empty) begin
            sel_state = SERVE1;
        end
    end

    // Next owner: backpressure wins over every selection.
    always_comb begin
        state_next = sel_state;
        if (down_almost_full) begin
            state_next = PAUSE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Output stage: capture the popped word; data and vc_id hold between words.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            vc_id     <= 1'b0;
        end else if (vc0_rd) begin
            data_out  <= vc0_data;
            valid_out <= 1'b1;
            vc_id     <= 1'b0;
        end else if (vc1_rd) begin
            data_out  <= vc1_data;
            valid_out <= 1'b1;
            vc_id     <= 1'b1;
        end else begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vc_drain_arbiter.sv
// Testbench for vc_drain_arbiter.
// The two FIFOs are modelled as queues whose empty flag reflects occupancy at the start of each cycle.
// Because of that, the flag naturally lags a pop by one cycle.
// A cycle-level reference model predicts the pop strobes and the registered outputs.
module tb_vc_drain_arbiter;

    localparam int BW     = 6;
    localparam int WEIGHT = 2;
`ifdef VC_DRAIN_WEIGHTED_RR_EN
    localparam bit WRR = 1'b1;
`else
    localparam bit WRR = 1'b0;
`endif

    localparam int OWN_NONE = 0;
    localparam int OWN_V0   = 1;
    localparam int OWN_V1   = 2;
    localparam int OWN_HOLD = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [BW-1:0] vc0_data;
    logic          vc0_empty;
    logic          vc0_almost_full;
    logic          vc0_rd;
    logic [BW-1:0] vc1_data;
    logic          vc1_empty;
    logic          vc1_almost_full;
    logic          vc1_rd;
    logic          down_almost_full;
    logic [BW-1:0] data_out;
    logic          valid_out;
    logic          vc_id;
    logic          idle;

    always #5 clk = ~clk;

    vc_drain_arbiter #(.BW(BW), .WEIGHT(WEIGHT)) dut (
        .clk              (clk),
        .reset            (reset),
        .vc0_data         (vc0_data),
        .vc0_empty        (vc0_empty),
        .vc0_almost_full  (vc0_almost_full),
        .vc0_rd           (vc0_rd),
        .vc1_data         (vc1_data),
        .vc1_empty        (vc1_empty),
        .vc1_almost_full  (vc1_almost_full),
        .vc1_rd           (vc1_rd),
        .down_almost_full (down_almost_full),
        .data_out         (data_out),
        .valid_out        (valid_out),
        .vc_id            (vc_id),
        .idle             (idle)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [BW-1:0] q0[$];
    logic [BW-1:0] q1[$];
    int            got[$];

    int            m_own = OWN_NONE;
    int            m_cnt = 0;
    logic [BW-1:0] e_data = '0;
    logic          e_valid = 1'b0;
    logic          e_vcid = 1'b0;

    typedef struct {
        int          n0;
        int          n1;
        logic [15:0] seq;
        int          len;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input int actual, input int expected);
        n_chk++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock cycle: present FIFO heads, check strobes, advance model, check outputs.
    task automatic cycle();
        bit x0;
        bit x1;
        int cnt_n;
        bit lim;
        int sel;
        vc0_empty = (q0.size() == 0);
        vc1_empty = (q1.size() == 0);
        vc0_data  = vc0_empty ? '0 : q0[0];
        vc1_data  = vc1_empty ? '0 : q1[0];
        #1;
        x0 = !reset && (m_own == OWN_V0) && !vc0_empty && !down_almost_full;
        x1 = !reset && (m_own == OWN_V1) && !vc1_empty && !down_almost_full;
        chk("vc0_rd", int'(vc0_rd), int'(x0));
        chk("vc1_rd", int'(vc1_rd), int'(x1));
        if (x1 || vc1_empty) cnt_n = 0;
        else if (x0 && m_cnt < WEIGHT) cnt_n = m_cnt + 1;
        else cnt_n = m_cnt;
        lim = WRR && (cnt_n == WEIGHT) && !vc1_empty;
        if (vc1_almost_full && !vc1_empty) sel = OWN_V1;
        else if (lim) sel = OWN_V1;
        else if (!vc0_empty) sel = OWN_V0;
        else if (!vc1_empty) sel = OWN_V1;
        else sel = OWN_NONE;
        @(posedge clk);
        if (reset) begin
            m_own = OWN_NONE;
            m_cnt = 0;
            e_data = '0;
            e_valid = 1'b0;
            e_vcid = 1'b0;
            q0.delete();
            q1.delete();
        end else begin
            if (x0) begin
                e_data = q0.pop_front();
                e_valid = 1'b1;
                e_vcid = 1'b0;
            end else if (x1) begin
                e_data = q1.pop_front();
                e_valid = 1'b1;
                e_vcid = 1'b1;
            end else begin
                e_valid = 1'b0;
            end
            m_own = down_almost_full ? OWN_HOLD : sel;
            m_cnt = cnt_n;
        end
        #1;
        chk("valid_out", int'(valid_out), int'(e_valid));
        chk("data_out", int'(data_out), int'(e_data));
        chk("vc_id", int'(vc_id), int'(e_vcid));
        chk("idle", int'(idle), int'(m_own == OWN_NONE));
        if (valid_out) got.push_back(int'(vc_id));
        @(negedge clk);
    endtask

    // Run until both FIFOs are drained, the last word is out and the owner is idle.
    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || m_own != OWN_NONE || e_valid) && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_within_budget", int'(n < budget), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] t2w[3];
        t2w[0] = 6'h05;
        t2w[1] = 6'h0A;
        t2w[2] = 6'h15;
        vecs[0] = '{3, 0, 16'h0000, 3};
        vecs[1] = '{2, 2, 16'h000C, 4};
        vecs[2] = '{0, 3, 16'h0007, 3};
        vecs[3] = '{6, 6, WRR ? 16'h0F24 : 16'h0FC0, 12};
        vecs[4] = '{1, 1, 16'h0002, 2};

        reset = 1'b1;
        down_almost_full = 1'b0;
        vc0_almost_full = 1'b0;
        vc1_almost_full = 1'b0;
        vc0_data = '0;
        vc1_data = '0;
        vc0_empty = 1'b1;
        vc1_empty = 1'b1;

        // Reset with both FIFOs non-empty: no pops, outputs cleared, idle.
        for (int i = 0; i < 2; i++) begin
            q0.push_back(6'h11);
            q1.push_back(6'h22);
            cycle();
        end
        reset = 1'b0;
        chk("reset_valid", int'(valid_out), 0);
        chk("reset_data", int'(data_out), 0);
        chk("reset_idle", int'(idle), 1);
        cycle();

        // Table-driven drains: compare the vc_id order of the output stream.
        for (int i = 0; i < 5; i++) begin
            got.delete();
            for (int k = 0; k < vecs[i].n0; k++) q0.push_back(i == 0 ? t2w[k] : BW'($urandom));
            for (int k = 0; k < vecs[i].n1; k++) q1.push_back(BW'($urandom));
            drain(60);
            chk($sformatf("vec%0d_len", i), got.size(), vecs[i].len);
            for (int k = 0; k < got.size() && k < 16; k++)
                chk($sformatf("vec%0d_seq%0d", i, k), got[k], int'(vecs[i].seq[k]));
        end

        // VC1 almost_full override in the cycle of the first VC0 pop.
        got.delete();
        for (int k = 0; k < 4; k++) q0.push_back(BW'(k + 1));
        q1.push_back(6'h31);
        q1.push_back(6'h32);
        cycle();
        vc1_almost_full = 1'b1;
        cycle();
        cycle();
        vc1_almost_full = 1'b0;
        drain(40);
        chk("af_len", got.size(), 6);
        if (got.size() == 6) begin
            chk("af_id1", got[1], 1);
            chk("af_id2", got[2], 1);
            chk("af_id3", got[3], 0);
        end

        // Downstream pause mid-drain: no pops, then resume without loss.
        got.delete();
        for (int k = 0; k < 5; k++) q0.push_back(BW'(6'h20 + k));
        cycle();
        cycle();
        cycle();
        down_almost_full = 1'b1;
        cycle();
        chk("pause_valid_next", int'(valid_out), 0);
        cycle();
        cycle();
        chk("pause_not_idle", int'(idle), 0);
        down_almost_full = 1'b0;
        drain(40);
        chk("pause_count", got.size(), 5);

        // Reset while VC0 is being served: strobe low, in-flight word dropped.
        q0.push_back(6'h2A);
        q0.push_back(6'h15);
        q0.push_back(6'h33);
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        chk("rst_mid_data", int'(data_out), 0);
        reset = 1'b0;
        cycle();

        // Randomized traffic against the reference model.
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 99) < 40 && q0.size() < 8) q0.push_back(BW'($urandom));
            if ($urandom_range(0, 99) < 35 && q1.size() < 8) q1.push_back(BW'($urandom));
            down_almost_full = ($urandom_range(0, 99) < 20);
            vc0_almost_full  = (q0.size() >= 6);
            vc1_almost_full  = ($urandom_range(0, 99) < 15) || (q1.size() >= 6);
            reset            = ($urandom_range(0, 199) == 0);
            cycle();
        end
        reset = 1'b0;
        down_almost_full = 1'b0;
        vc0_almost_full = 1'b0;
        vc1_almost_full = 1'b0;
        drain(100);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
